ins_cache: RTL and testbench
============================

Name: ins_cache

Overview:
- Direct-mapped instruction cache between the CPU PC/instruction port and the 16-byte-block instruction memory.
- It is the initiator side of the memory's read/busywait block protocol.
- On a hit it returns a 32-bit instruction combinationally. On a miss it stalls the CPU, fetches the 128-bit block, installs it, then serves the word.

Parameters:
- ADDR_W, 10, CPU byte-address width (1024-byte instruction space).
- INDEX_W, 3, line index width (2^INDEX_W = 8 lines of 16 bytes).
- Derived: TAG_W = ADDR_W-4-INDEX_W (3); MEM_ADDR_W = ADDR_W-4 (6).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- read  in  1  CPU fetch request (held high while fetching).
- address  in  ADDR_W  CPU byte address (PC); [1:0] ignored.
- instruction  out  32  fetched instruction word.
- busywait  out  1  CPU stall; CPU holds address/read while high.
- mem_read  out  1  block read request to instruction memory.
- mem_address  out  MEM_ADDR_W  block address {tag,index}.
- mem_readdata  in  128  block from memory; byte k at bits [8k+7:8k].
- mem_busywait  in  1  memory busy; falls when mem_readdata valid.

Behaviour:
- Address split: tag = address[ADDR_W-1:INDEX_W+4]; index = address[INDEX_W+3:4]; word offset = address[3:2].
- Per-line storage: valid bit, TAG_W tag, 128-bit data.
- hit = read & valid[index] & (tag_store[index]==tag), combinational.
- instruction = data[index] word at offset (offset 0 -> bits[31:0], 3 -> bits[127:96]), combinational. Value is don't-care when not hit.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - busywait = read & ~hit; mem_read = 0.
  - Miss -> MEM_READ at next edge. Hit or read=0 -> stay.
- MEM_READ:
  - mem_read = 1; mem_address = {tag,index} from the current address; busywait = 1.
  - Stay while mem_busywait=1.
  - mem_busywait=0 at an edge -> UPDATE. The first MEM_READ edge is never exited: it requires ≥1 cycle in MEM_READ, because memory raises busywait the same delta read rises.
- UPDATE:
  - mem_read = 0; busywait = 1.
  - At the edge: data[index] <= mem_readdata, tag_store[index] <= tag, valid[index] <= 1; -> IDLE.
  - Next cycle hits, so busywait drops.
- Miss penalty: IDLE(1) + MEM_READ(n, until memory releases) + UPDATE(1) cycles. A hit costs 0 stall cycles.
- Replacement: on a conflict miss the new block overwrites the line unconditionally; no writeback (read-only cache).
- read=0: busywait=0 in IDLE. A fetch already in flight still completes and installs the line.
- Address must be stable while busywait=1. Behaviour on a change is undefined for the bench; the RTL uses the live address.
- Reset (synchronous, any state including mid-MEM_READ):
  - All valid bits <= 0; state <= IDLE.
  - Outputs: mem_read=0, busywait = read (every access misses).
  - The aborted line is not installed. Tag/data arrays need not be cleared.
- Simultaneous reset and mem_busywait fall: reset wins.
- mem_address = 0 in IDLE/UPDATE.

Optional Feature:
- ICACHE_STATS_EN defined: adds output ports hit_count[15:0] and miss_count[15:0].
  - Both reset to 0 on reset.
  - hit_count increments on each edge in IDLE with hit=1.
  - miss_count increments on each IDLE->MEM_READ transition.
  - Both saturate at 16'hFFFF.
- Not defined: ports and counters absent; functionality otherwise identical.

Test Plan:
- Reset, then read=1, address=0x000, memory holds 0x00040019 at byte 0 -> busywait=1, mem_read=1, mem_address=6'd0 until mem_busywait falls. After UPDATE: instruction=0x00040019, busywait=0.
- After the first fill, address=0x004 then 0x008 -> immediate hits, instruction=0x00050023 then 0x02060405, busywait never rises, mem_read stays 0.
- Address 0x080 (tag 1, index 0) after line 0 filled -> miss, mem_address=6'd8, line replaced. Then 0x000 -> miss again (conflict), mem_address=6'd0.
- Assert reset during MEM_READ -> next cycle mem_read=0, state IDLE. Re-request 0x000 -> misses (line not valid) and refetches correctly.
- read=0 with arbitrary address -> busywait=0, mem_read=0, no state change for 10 cycles.
- With ICACHE_STATS_EN: sequence miss 0x000, hits 0x004/0x008/0x00C, miss 0x010 -> miss_count=2, hit_count counts 3 hits plus post-fill hit cycles as defined; reset -> both 0.

Source files
------------

// File: rtl/ins_cache.sv
// Direct-mapped, read-only instruction cache: combinational hit path, block refill over the read/busywait protocol.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count output ports.
module ins_cache #(
  parameter int ADDR_W  = 10,
  parameter int INDEX_W = 3,
  localparam int TAG_W      = ADDR_W - 4 - INDEX_W,
  localparam int MEM_ADDR_W = ADDR_W - 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic [ADDR_W-1:0]     address,
  output logic [31:0]           instruction,
  output logic                  busywait,
  output logic                  mem_read,
  output logic [MEM_ADDR_W-1:0] mem_address,
  input  logic [127:0]          mem_readdata,
  input  logic                  mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    UPDATE
  } state_t;

  state_t             state;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_store  [LINES];
  logic [127:0]       data_store [LINES];
  logic               first_edge;

  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] index;
  logic [1:0]         offset;
  logic               hit;
  logic               unused_addr_bits;

  assign tag              = address[ADDR_W-1:INDEX_W+4];
  assign index            = address[INDEX_W+3:4];
  assign offset           = address[3:2];
  assign unused_addr_bits = ^address[1:0];

  assign hit         = read & valid[index] & (tag_store[index] == tag);
  assign instruction = data_store[index][{offset, 5'b00000} +: 32];

  always_comb begin
    busywait    = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    case (state)
      IDLE: busywait = read & ~hit;
      MEM_READ: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {tag, index};
      end
      UPDATE: busywait = 1'b1;
      default: ;
    endcase
  end

  // The memory raises busywait in the same delta as mem_read, so the first
  // MEM_READ edge is always spent waiting regardless of mem_busywait.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      first_edge <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read && !hit) begin
            state      <= MEM_READ;
            first_edge <= 1'b1;
          end
        end
        MEM_READ: begin
          first_edge <= 1'b0;
          if (!first_edge && !mem_busywait) state <= UPDATE;
        end
        UPDATE: begin
          valid[index] <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays are never cleared; the valid bits alone qualify them.
  always_ff @(posedge clock) begin
    if (!reset && state == UPDATE) begin
      data_store[index] <= mem_readdata;
      tag_store[index]  <= tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE) begin
      if (hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (read && !hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ins_cache.sv
// Testbench for ins_cache: directed fetches against a bench-side memory and a line-level cache model.
// Stats ports are checked only when ICACHE_STATS_EN is defined.
module tb_ins_cache;

  logic         clock = 1'b0;
  logic         reset;
  logic         read;
  logic [9:0]   address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  ins_cache dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clock = ~clock;

  logic [7:0]  mem_bytes [1024];
  int          mem_lat = 3;
  int          mem_cnt = 0;

  logic        m_valid [8];
  logic [2:0]  m_tag   [8];
  int          m_hits = 0;
  int          m_misses = 0;

  logic        chk_en = 1'b0;
  logic        exp_busy, exp_mem_read, exp_instr_en;
  logic [5:0]  exp_mem_addr;
  logic [31:0] exp_instr;

  int          checks = 0;
  int          failures = 0;
  int          cur_stall = 0;
  int          last_stall = 0;
  logic [5:0]  last_mem_addr = '0;

  function automatic logic [127:0] block_of(input logic [5:0] ba);
    logic [127:0] b;
    for (int k = 0; k < 16; k++) b[8*k +: 8] = mem_bytes[{ba, 4'(k)}];
    return b;
  endfunction

  function automatic logic [31:0] word_at(input logic [9:0] a);
    logic [9:0] base;
    base = {a[9:2], 2'b00};
    return {mem_bytes[base | 10'd3], mem_bytes[base | 10'd2], mem_bytes[base | 10'd1], mem_bytes[base]};
  endfunction

  // Memory: latches the addressed block every requested cycle, releases busywait after mem_lat edges.
  always @(posedge clock) begin
    if (mem_read) begin
      mem_cnt      <= mem_cnt + 1;
      mem_readdata <= block_of(mem_address);
    end else begin
      mem_cnt <= 0;
    end
  end
  assign mem_busywait = mem_read && (mem_cnt < mem_lat);

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (busywait === 1'b1) cur_stall++;
    else if (cur_stall > 0) begin
      last_stall = cur_stall;
      cur_stall  = 0;
    end
    if (mem_read === 1'b1) last_mem_addr = mem_address;
    if (chk_en) begin
      check_output("busywait", 32'(busywait), 32'(exp_busy));
      check_output("mem_read", 32'(mem_read), 32'(exp_mem_read));
      check_output("mem_address", 32'(mem_address), 32'(exp_mem_addr));
      if (exp_instr_en) check_output("instruction", instruction, exp_instr);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One complete fetch: a miss stalls for IDLE + MEM_READ(max(lat,1)+1) + UPDATE cycles.
  task automatic apply_stimulus(input logic [9:0] addr);
    logic [2:0] idx;
    logic [2:0] tg;
    logic       is_hit;
    int         n;
    int         s;
    idx    = addr[6:4];
    tg     = addr[9:7];
    is_hit = m_valid[idx] && (m_tag[idx] == tg);
    n      = ((mem_lat < 1) ? 1 : mem_lat) + 1;
    s      = is_hit ? 0 : n + 2;
    address = addr;
    read    = 1'b1;
    for (int c = 0; c <= s; c++) begin
      exp_busy     = (c < s);
      exp_mem_read = (c >= 1) && (c <= n);
      exp_mem_addr = exp_mem_read ? {tg, idx} : 6'd0;
      exp_instr_en = (c == s);
      exp_instr    = word_at(addr);
      chk_en       = 1'b1;
      step();
    end
    chk_en = 1'b0;
    if (!is_hit) m_misses++;
    m_hits++;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
  endtask

  initial begin
    for (int w = 0; w < 256; w++) begin
      logic [31:0] v;
      v = 32'hC0DE0000 | 32'(w * 7);
      for (int b = 0; b < 4; b++) mem_bytes[4*w + b] = v[8*b +: 8];
    end
    {mem_bytes[3], mem_bytes[2], mem_bytes[1], mem_bytes[0]}    = 32'h00040019;
    {mem_bytes[7], mem_bytes[6], mem_bytes[5], mem_bytes[4]}    = 32'h00050023;
    {mem_bytes[11], mem_bytes[10], mem_bytes[9], mem_bytes[8]}  = 32'h02060405;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 3'd0;
    end
    exp_busy = 1'b0; exp_mem_read = 1'b0; exp_instr_en = 1'b0;
    exp_mem_addr = '0; exp_instr = '0;

    reset = 1'b1; read = 1'b0; address = '0;
    repeat (2) step();
    check_output("rst_busywait", 32'(busywait), 32'd0);
    check_output("rst_mem_read", 32'(mem_read), 32'd0);
    read = 1'b1;
    #1;
    check_output("rst_busy_eq_read", 32'(busywait), 32'd1);
    step();
    check_output("rst_holds_idle", 32'(mem_read), 32'd0);
    read = 1'b0;
    step();
    reset = 1'b0;

    apply_stimulus(10'h000);
    check_output("lit_word0", instruction, 32'h00040019);
    check_output("lit_stall_lat3", 32'(last_stall), 32'd6);
    check_output("lit_maddr0", 32'(last_mem_addr), 32'd0);
    apply_stimulus(10'h004);
    check_output("lit_word1", instruction, 32'h00050023);
    apply_stimulus(10'h008);
    check_output("lit_word2", instruction, 32'h02060405);
    apply_stimulus(10'h00C);

    apply_stimulus(10'h080);
    check_output("lit_maddr8", 32'(last_mem_addr), 32'd8);
    apply_stimulus(10'h000);
    check_output("lit_conflict_maddr", 32'(last_mem_addr), 32'd0);
    check_output("lit_conflict_word", instruction, 32'h00040019);
    apply_stimulus(10'h004);

    mem_lat = 0;
    apply_stimulus(10'h010);
    check_output("lit_stall_lat0", 32'(last_stall), 32'd4);
    mem_lat = 1;
    apply_stimulus(10'h3F4);
    apply_stimulus(10'h3F8);
    mem_lat = 3;

    read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      address      = 10'($urandom);
      exp_busy     = 1'b0;
      exp_mem_read = 1'b0;
      exp_mem_addr = 6'd0;
      exp_instr_en = 1'b0;
      chk_en       = 1'b1;
      step();
    end
    chk_en = 1'b0;
    apply_stimulus(10'h004);
    apply_stimulus(10'h3F4);

`ifdef ICACHE_STATS_EN
    check_output("hit_count", 32'(hit_count), 32'(m_hits));
    check_output("miss_count", 32'(miss_count), 32'(m_misses));
`endif

    // Abort a refill with reset while the cache is in MEM_READ.
    address = 10'h020;
    read    = 1'b1;
    exp_instr_en = 1'b0;
    exp_busy = 1'b1; exp_mem_read = 1'b0; exp_mem_addr = 6'd0; chk_en = 1'b1;
    step();
    exp_mem_read = 1'b1; exp_mem_addr = 6'd2;
    step();
    reset = 1'b1;
    step();
    chk_en = 1'b0;
    reset  = 1'b0;
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
    check_output("abort_mem_read", 32'(mem_read), 32'd0);
    check_output("abort_busy_eq_read", 32'(busywait), 32'd1);
`ifdef ICACHE_STATS_EN
    check_output("rst_hit_count", 32'(hit_count), 32'd0);
    check_output("rst_miss_count", 32'(miss_count), 32'd0);
`endif
    apply_stimulus(10'h020);
    apply_stimulus(10'h000);
    check_output("lit_refetch_word", instruction, 32'h00040019);
    check_output("lit_refetch_stall", 32'(last_stall), 32'd6);

`ifdef ICACHE_STATS_EN
    check_output("hit_count_end", 32'(hit_count), 32'(m_hits));
    check_output("miss_count_end", 32'(miss_count), 32'(m_misses));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
